spi_slave_frame_responder: RTL and testbench
============================================

Name: spi_slave_frame_responder

Overview:
- SPI mode-0 slave front-end; the far end of the link the SPI master subsystem drives.
- Decodes each chip-select frame into a command field, an address field and a data field, using the same lengths and flag semantics as the verification collector packet (cmd_len, addr_len, mosi_data_len, flag).
- Write frames: captures MOSI data.
- Read frames: shifts return data out on MISO.
- Sits between the SPI pads and a simple register/memory responder.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for sclk, cs_n and mosi (min 2).
- MAX_LEN, 32, maximum bits per field; longer programmed lengths are clamped to MAX_LEN.

Ports:
- clk  in  1  system clock; must run at least 8x sclk.
- rst  in  1  asynchronous, active-high reset.
- spi_sclk  in  1  SPI clock, async to clk, idle low.
- spi_cs_n  in  1  chip select, active low, async.
- spi_mosi  in  1  master-out data, MSB first.
- spi_miso  out  1  slave-out data.
- spi_miso_oe  out  1  MISO output enable.
- cfg_cmd_len  in  6  command bits per frame (0..32).
- cfg_addr_len  in  6  address bits per frame (0..32).
- cfg_data_len  in  16  data bits per frame (0..MAX_LEN after clamp).
- cfg_rd  in  1  frame direction: 1 = read (drive MISO), 0 = write (capture MOSI).
- tx_data  in  32  read data, MSB-aligned to cfg_data_len, sampled in the hdr_valid cycle.
- hdr_valid  out  1  one-cycle pulse when the cmd+addr phase is complete.
- hdr_cmd  out  32  received command, right-aligned.
- hdr_addr  out  32  received address, right-aligned.
- frame_valid  out  1  one-cycle pulse at frame end.
- rx_data  out  32  received MOSI data, right-aligned; 0 for read frames.
- frame_flag  out  2  frame status: 00 = ok, 01 = aborted, 10 = overrun (extra clocks after data phase).

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, hdr_valid=0, frame_valid=0, hdr_cmd=0, hdr_addr=0, rx_data=0, frame_flag=00, state=IDLE. Reset acts immediately, including mid-frame; no frame_valid is produced for a frame interrupted by reset.
- Input sync and edge detect: sclk, cs_n and mosi pass through SYNC_STAGES flops. Edges are detected on the synchronized signals; the detect is seen SYNC_STAGES+1 clk after the pin change.
- Sampling: MOSI sampled on detected sclk rise. MISO updated on detected sclk fall.
- Config capture: cfg_* is latched on the detected cs_n falling edge and held for the whole frame. Lengths above MAX_LEN are clamped.
- States: IDLE -> CMD -> ADDR -> DATA -> DONE -> IDLE.
  - IDLE -> CMD on cs_n fall. A zero-length phase is skipped in the same cycle, so IDLE can jump straight to ADDR, DATA or DONE.
  - A 6-bit bit counter loads the phase length on entry and decrements on each sampled rise. The phase ends when the counter reaches 0.
  - Fields shift in MSB first and are right-aligned.
- hdr_valid:
  - Pulses the clk after the final address bit is sampled, or at frame start if cmd_len=addr_len=0.
  - hdr_cmd and hdr_addr are valid from that cycle until the next frame's hdr_valid.
- Read frames (cfg_rd=1):
  - tx_data is latched in the hdr_valid cycle.
  - spi_miso_oe=1 from the hdr_valid cycle until cs_n rises.
  - MSB is driven in the cycle after hdr_valid; each later bit follows a detected fall.
  - After the last data bit, MISO holds 0.
- Write frames (cfg_rd=0): spi_miso_oe stays 0 and spi_miso stays 0.
- DONE: reached when the data counter hits 0. Any further sclk rise before cs_n rises sets an overrun indicator, and those bits are ignored.
- Frame end:
  - On the detected cs_n rise, frame_valid pulses for 1 cycle.
  - frame_flag = 00 if state was DONE with no extra clocks, 10 if overrun, 01 if cs_n rose before DONE.
  - After an abort, rx_data holds the partial bits received, right-aligned.
  - spi_miso_oe drops in the same cycle, and state returns to IDLE.
- Simultaneous events: if cs_n rise and an sclk rise are detected in the same cycle, cs_n wins and the sclk edge is ignored.
- cs_n glitch: a cs_n fall while not in IDLE cannot occur after sync. A cs_n rise while in IDLE is ignored.

Test Plan:
- Write frame: cmd_len=8, addr_len=32, data_len=32, rd=0; send cmd 0x02, addr 0x1A102000, data 0xDEADBEEF -> hdr_valid once with hdr_cmd=0x02, hdr_addr=0x1A102000; frame_valid with rx_data=0xDEADBEEF, flag=00; miso_oe stays 0.
- Read frame: cmd_len=8, addr_len=24, data_len=16, rd=1, tx_data=0xA5C3_0000 -> MISO sampled by master = 0xA5C3; miso_oe high only from hdr_valid to cs_n rise; flag=00.
- Zero-length header: cmd_len=0, addr_len=0, data_len=8, rd=1, tx_data=0x81000000 -> hdr_valid at frame start; master reads 0x81.
- Abort: cmd_len=8, addr_len=8, data_len=32; raise cs_n after 20 data bits of 0xFFFFF -> frame_valid, flag=01, rx_data=0x000FFFFF.
- Overrun: data_len=8, 10 data clocks -> rx_data holds the first 8 bits, flag=10. Clamp case: data_len=40 behaves as 32.
- Reset mid-frame: assert rst during ADDR -> all outputs 0 immediately, no frame_valid; the next frame decodes correctly.

Source files
------------

// File: rtl/spi_slave_frame_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : spi_slave_frame_responder
// Brief   : SPI mode-0 slave; splits each chip-select frame into command,
//           address and data fields, captures write data, returns read data.
// Revision: 1.0 - initial release
// ============================================================================
module spi_slave_frame_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_LEN     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [5:0]  cfg_cmd_len,
  input  logic [5:0]  cfg_addr_len,
  input  logic [15:0] cfg_data_len,
  input  logic        cfg_rd,
  input  logic [31:0] tx_data,
  output logic        hdr_valid,
  output logic [31:0] hdr_cmd,
  output logic [31:0] hdr_addr,
  output logic        frame_valid,
  output logic [31:0] rx_data,
  output logic [1:0]  frame_flag
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [5:0]  c_max_len    = 6'(MAX_LEN);
  localparam logic [15:0] c_max_len_16 = 16'(MAX_LEN);

  // Input synchronizers and edge detection
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sclk, w_cs, w_mosi;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;

  // Clamped view of the live configuration, latched at frame start
  logic [5:0] w_cmd_len_in, w_addr_len_in, w_data_len_in;

  assign w_cmd_len_in  = (cfg_cmd_len > c_max_len) ? c_max_len : cfg_cmd_len;
  assign w_addr_len_in = (cfg_addr_len > c_max_len) ? c_max_len : cfg_addr_len;
  assign w_data_len_in = (cfg_data_len > c_max_len_16) ? c_max_len : cfg_data_len[5:0];

  state_t      r_state, w_state_n;
  logic [5:0]  r_cnt;
  logic [5:0]  r_cmd_len, r_addr_len, r_data_len;
  logic        r_rd;
  logic        r_overrun;
  logic        r_pend;
  logic [31:0] r_cmd_sh, r_addr_sh, r_rx_sh;
  logic [30:0] r_tx_sh;
  logic        r_hdr_valid, r_frame_valid, r_miso, r_miso_oe;
  logic [31:0] r_hdr_cmd, r_hdr_addr, r_rx_data;
  logic [1:0]  r_frame_flag;

  logic        w_cnt_load;
  logic [5:0]  w_cnt_val;
  logic        w_frame_start, w_frame_end, w_hdr_fire;
  logic        w_shift_cmd, w_shift_addr, w_shift_data, w_overrun_set;
  logic [1:0]  w_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // cs_n rise is tested first in every active state so it wins over sclk
  always_comb begin
    w_state_n     = r_state;
    w_cnt_load    = 1'b0;
    w_cnt_val     = '0;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    w_hdr_fire    = 1'b0;
    w_shift_cmd   = 1'b0;
    w_shift_addr  = 1'b0;
    w_shift_data  = 1'b0;
    w_overrun_set = 1'b0;
    w_flag        = 2'b01;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_frame_start = 1'b1;
          w_cnt_load    = 1'b1;
          if (w_cmd_len_in != '0) begin
            w_state_n = S_CMD;
            w_cnt_val = w_cmd_len_in;
          end else if (w_addr_len_in != '0) begin
            w_state_n = S_ADDR;
            w_cnt_val = w_addr_len_in;
          end else begin
            w_hdr_fire = 1'b1;
            w_cnt_val  = w_data_len_in;
            w_state_n  = (w_data_len_in != '0) ? S_DATA : S_DONE;
          end
        end
      end
      S_CMD: begin
        if (w_cs_rise) begin
          w_frame_end = 1'b1;
          w_state_n   = S_IDLE;
        end else if (w_sclk_rise) begin
          w_shift_cmd = 1'b1;
          if (r_cnt == 6'd1) begin
            w_cnt_load = 1'b1;
            if (r_addr_len != '0) begin
              w_state_n = S_ADDR;
              w_cnt_val = r_addr_len;
            end else begin
              w_hdr_fire = 1'b1;
              w_cnt_val  = r_data_len;
              w_state_n  = (r_data_len != '0) ? S_DATA : S_DONE;
            end
          end
        end
      end
      S_ADDR: begin
        if (w_cs_rise) begin
          w_frame_end = 1'b1;
          w_state_n   = S_IDLE;
        end else if (w_sclk_rise) begin
          w_shift_addr = 1'b1;
          if (r_cnt == 6'd1) begin
            w_cnt_load = 1'b1;
            w_hdr_fire = 1'b1;
            w_cnt_val  = r_data_len;
            w_state_n  = (r_data_len != '0) ? S_DATA : S_DONE;
          end
        end
      end
      S_DATA: begin
        if (w_cs_rise) begin
          w_frame_end = 1'b1;
          w_state_n   = S_IDLE;
        end else if (w_sclk_rise) begin
          w_shift_data = 1'b1;
          if (r_cnt == 6'd1) w_state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (w_cs_rise) begin
          w_frame_end = 1'b1;
          w_state_n   = S_IDLE;
        end else if (w_sclk_rise) begin
          w_overrun_set = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (r_state == S_DONE) w_flag = r_overrun ? 2'b10 : 2'b00;
  end

  // Header fields as they will stand after this cycle's shift
  logic [31:0] w_cmd_next, w_addr_next;
  logic        w_rd;

  assign w_cmd_next  = w_frame_start ? '0 :
                       (w_shift_cmd ? {r_cmd_sh[30:0], w_mosi} : r_cmd_sh);
  assign w_addr_next = w_frame_start ? '0 :
                       (w_shift_addr ? {r_addr_sh[30:0], w_mosi} : r_addr_sh);
  assign w_rd        = w_frame_start ? cfg_rd : r_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_cmd_len     <= '0;
      r_addr_len    <= '0;
      r_data_len    <= '0;
      r_rd          <= 1'b0;
      r_overrun     <= 1'b0;
      r_pend        <= 1'b0;
      r_cmd_sh      <= '0;
      r_addr_sh     <= '0;
      r_rx_sh       <= '0;
      r_tx_sh       <= '0;
      r_hdr_valid   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_hdr_cmd     <= '0;
      r_hdr_addr    <= '0;
      r_rx_data     <= '0;
      r_frame_flag  <= 2'b00;
    end else begin
      r_hdr_valid   <= w_hdr_fire;
      r_frame_valid <= w_frame_end;
      r_cmd_sh      <= w_cmd_next;
      r_addr_sh     <= w_addr_next;

      if (w_cnt_load)
        r_cnt <= w_cnt_val;
      else if (w_shift_cmd || w_shift_addr || w_shift_data)
        r_cnt <= r_cnt - 6'd1;

      if (w_frame_start) begin
        r_cmd_len  <= w_cmd_len_in;
        r_addr_len <= w_addr_len_in;
        r_data_len <= w_data_len_in;
        r_rd       <= cfg_rd;
        r_rx_sh    <= '0;
        r_overrun  <= 1'b0;
        r_pend     <= 1'b0;
      end

      if (w_shift_data) begin
        r_rx_sh <= {r_rx_sh[30:0], w_mosi};
        r_pend  <= 1'b1;
      end
      if (w_overrun_set) r_overrun <= 1'b1;

      if (w_hdr_fire) begin
        r_hdr_cmd  <= w_cmd_next;
        r_hdr_addr <= w_addr_next;
        r_miso_oe  <= w_rd;
      end

      // The fall that closes the header clock must not consume the MSB;
      // only falls that follow a sampled data bit advance MISO.
      if (r_hdr_valid && r_rd) begin
        r_tx_sh <= tx_data[30:0];
        r_miso  <= (r_data_len != '0) && tx_data[31];
      end else if (w_sclk_fall && r_pend && r_miso_oe) begin
        r_pend  <= 1'b0;
        r_tx_sh <= {r_tx_sh[29:0], 1'b0};
        r_miso  <= (r_state == S_DATA) && r_tx_sh[30];
      end

      if (w_frame_end) begin
        r_rx_data    <= r_rd ? '0 : r_rx_sh;
        r_frame_flag <= w_flag;
        r_miso_oe    <= 1'b0;
        r_miso       <= 1'b0;
        r_pend       <= 1'b0;
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_miso_oe;
  assign hdr_valid   = r_hdr_valid;
  assign hdr_cmd     = r_hdr_cmd;
  assign hdr_addr    = r_hdr_addr;
  assign frame_valid = r_frame_valid;
  assign rx_data     = r_rx_data;
  assign frame_flag  = r_frame_flag;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_frame_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave_frame_responder
// Brief   : Directed frames driven as an SPI mode-0 master with fixed results.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_slave_frame_responder;

  localparam int HALF = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [5:0]  cfg_cmd_len, cfg_addr_len;
  logic [15:0] cfg_data_len;
  logic        cfg_rd;
  logic [31:0] tx_data;
  logic        hdr_valid, frame_valid;
  logic [31:0] hdr_cmd, hdr_addr, rx_data;
  logic [1:0]  frame_flag;

  int n_checks = 0;
  int n_errors = 0;
  int hdr_cnt  = 0;
  int frm_cnt  = 0;
  int oe_cyc   = 0;
  logic hdr_oe = 1'b0;
  logic frm_oe = 1'b0;

  spi_slave_frame_responder #(.SYNC_STAGES(2), .MAX_LEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .cfg_cmd_len  (cfg_cmd_len),
    .cfg_addr_len (cfg_addr_len),
    .cfg_data_len (cfg_data_len),
    .cfg_rd       (cfg_rd),
    .tx_data      (tx_data),
    .hdr_valid    (hdr_valid),
    .hdr_cmd      (hdr_cmd),
    .hdr_addr     (hdr_addr),
    .frame_valid  (frame_valid),
    .rx_data      (rx_data),
    .frame_flag   (frame_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (hdr_valid) begin
      hdr_cnt = hdr_cnt + 1;
      hdr_oe  = spi_miso_oe;
    end
    if (frame_valid) begin
      frm_cnt = frm_cnt + 1;
      frm_oe  = spi_miso_oe;
    end
    if (spi_miso_oe) oe_cyc = oe_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    #(HALF);
    spi_sclk = 1'b1;
    m = spi_miso;
    #(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic set_cfg(input int cl, input int al, input int dl, input logic rd);
    cfg_cmd_len  = 6'(cl);
    cfg_addr_len = 6'(al);
    cfg_data_len = 16'(dl);
    cfg_rd       = rd;
  endtask

  // dn = number of data clocks actually sent (may differ from data_len)
  task automatic spi_frame(input logic [31:0] cmd, input int cl,
                           input logic [31:0] addr, input int al,
                           input logic [31:0] data, input int dn,
                           output logic [31:0] rd_word, output int early_hdr);
    logic m;
    int   h0;
    @(negedge clk);
    h0 = hdr_cnt;
    spi_cs_n = 1'b0;
    #(HALF);
    early_hdr = hdr_cnt - h0;
    for (int i = 0; i < cl; i++) spi_bit(cmd[cl-1-i], m);
    for (int i = 0; i < al; i++) spi_bit(addr[al-1-i], m);
    rd_word = '0;
    for (int i = 0; i < dn; i++) begin
      spi_bit(data[dn-1-i], m);
      rd_word = {rd_word[30:0], m};
    end
    #(HALF);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    logic [31:0] word;
    logic        m;
    int          early, h0, f0, o0;

    rst = 1'b1;
    spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    set_cfg(0, 0, 0, 1'b0);
    tx_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_oe",    32'(spi_miso_oe), 32'd0);
    chk("rst_miso",  32'(spi_miso), 32'd0);
    chk("rst_hdrv",  32'(hdr_valid), 32'd0);
    chk("rst_frmv",  32'(frame_valid), 32'd0);
    chk("rst_rx",    rx_data, 32'd0);
    chk("rst_flag",  32'(frame_flag), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Write frame
    set_cfg(8, 32, 32, 1'b0);
    h0 = hdr_cnt; f0 = frm_cnt; o0 = oe_cyc;
    spi_frame(32'h02, 8, 32'h1A102000, 32, 32'hDEADBEEF, 32, word, early);
    chk("wr_hdr_cnt", 32'(hdr_cnt - h0), 32'd1);
    chk("wr_cmd",     hdr_cmd, 32'h02);
    chk("wr_addr",    hdr_addr, 32'h1A102000);
    chk("wr_frm_cnt", 32'(frm_cnt - f0), 32'd1);
    chk("wr_rx",      rx_data, 32'hDEADBEEF);
    chk("wr_flag",    32'(frame_flag), 32'd0);
    chk("wr_oe_cyc",  32'(oe_cyc - o0), 32'd0);

    // Read frame
    set_cfg(8, 24, 16, 1'b1);
    tx_data = 32'hA5C3_0000;
    h0 = hdr_cnt; f0 = frm_cnt; o0 = oe_cyc;
    spi_frame(32'h03, 8, 32'h001000, 24, 32'h0, 16, word, early);
    chk("rd_miso",    word, 32'h0000A5C3);
    chk("rd_addr",    hdr_addr, 32'h001000);
    chk("rd_hdr_oe",  32'(hdr_oe), 32'd1);
    chk("rd_frm_oe",  32'(frm_oe), 32'd0);
    chk("rd_oe_seen", 32'(oe_cyc - o0 > 40), 32'd1);
    chk("rd_frm_cnt", 32'(frm_cnt - f0), 32'd1);
    chk("rd_flag",    32'(frame_flag), 32'd0);
    chk("rd_rx_zero", rx_data, 32'd0);

    // Zero-length header
    set_cfg(0, 0, 8, 1'b1);
    tx_data = 32'h8100_0000;
    spi_frame(32'h0, 0, 32'h0, 0, 32'h0, 8, word, early);
    chk("zh_early",   32'(early), 32'd1);
    chk("zh_miso",    word, 32'h81);
    chk("zh_addr",    hdr_addr, 32'd0);
    chk("zh_flag",    32'(frame_flag), 32'd0);

    // Abort after 20 of 32 data bits
    set_cfg(8, 8, 32, 1'b0);
    f0 = frm_cnt;
    spi_frame(32'hA1, 8, 32'h5E, 8, 32'h000FFFFF, 20, word, early);
    chk("ab_frm_cnt", 32'(frm_cnt - f0), 32'd1);
    chk("ab_flag",    32'(frame_flag), 32'd1);
    chk("ab_rx",      rx_data, 32'h000FFFFF);

    // Clamp: data_len 40 acts as 32
    set_cfg(8, 8, 40, 1'b0);
    spi_frame(32'h11, 8, 32'h22, 8, 32'h12345678, 32, word, early);
    chk("cl_flag",    32'(frame_flag), 32'd0);
    chk("cl_rx",      rx_data, 32'h12345678);

    // Overrun: 10 clocks into an 8-bit data phase
    set_cfg(8, 8, 8, 1'b0);
    spi_frame(32'h33, 8, 32'h44, 8, 32'h2A5, 10, word, early);
    chk("ov_flag",    32'(frame_flag), 32'd2);
    chk("ov_rx",      rx_data, 32'hA9);
    chk("ov_cmd",     hdr_cmd, 32'h33);

    // Reset during the address phase
    set_cfg(8, 8, 8, 1'b0);
    @(negedge clk);
    f0 = frm_cnt;
    spi_cs_n = 1'b0;
    #(HALF);
    for (int i = 0; i < 8; i++) spi_bit(1'b1, m);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, m);
    #(HALF/2);
    rst = 1'b1;
    #1;
    chk("mr_cmd",  hdr_cmd, 32'd0);
    chk("mr_addr", hdr_addr, 32'd0);
    chk("mr_rx",   rx_data, 32'd0);
    chk("mr_flag", 32'(frame_flag), 32'd0);
    chk("mr_oe",   32'(spi_miso_oe), 32'd0);
    spi_cs_n = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("mr_no_frm", 32'(frm_cnt - f0), 32'd0);

    // Recovery frame
    h0 = hdr_cnt; f0 = frm_cnt;
    spi_frame(32'h5A, 8, 32'h3C, 8, 32'h96, 8, word, early);
    chk("rc_hdr_cnt", 32'(hdr_cnt - h0), 32'd1);
    chk("rc_cmd",     hdr_cmd, 32'h5A);
    chk("rc_addr",    hdr_addr, 32'h3C);
    chk("rc_frm_cnt", 32'(frm_cnt - f0), 32'd1);
    chk("rc_rx",      rx_data, 32'h96);
    chk("rc_flag",    32'(frame_flag), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
